run_timer: RTL and testbench

Game run-time timekeeper placed directly upstream of the four-digit `SevenSegment` driver. It counts display frames (rising `vsync` edges) while a run is in progress and converts them to a saturating mm:ss BCD value. It tracks game state through start, pause and game over, keeps a best-run record, and presents either the current or the best time on `nums`.

---
 rtl/dino_pkg.sv | 15 +
 rtl/bcd_digit.sv | 29 ++
 rtl/run_timer.sv | 151 +++++++++++++++
 tb/tb_run_timer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and constants for the run timer: FSM state encoding,
// the mm:ss saturation value and the default frame rate.
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } run_state_t;

    localparam logic [15:0] BCD_TIME_MAX       = 16'h9959;
    localparam int          FRAMES_PER_SEC_DEF = 60;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the time cascade. Counts 0..MOD-1 while enabled.
// co flags the enabled step that rolls the digit over, so it can drive
// the enable of the next digit up.
module bcd_digit #(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       co
);

    localparam logic [3:0] DMAX = 4'(MOD - 1);

    assign co = en && (digit == DMAX);

    // Digit register: clear has priority, then roll over or increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            digit <= 4'd0;
        else if (clr)
            digit <= 4'd0;
        else if (en)
            digit <= co ? 4'd0 : digit + 4'd1;
    end

endmodule

// File: rtl/run_timer.sv
// Game run-time timekeeper: counts vsync frames during a run, converts
// them to a saturating mm:ss BCD value and keeps a best-run record.
// Optional feature macro: RUN_TIMER_BEST_EN (best register, compare,
// new_best pulse and show_best mux). Without it nums shows the current time.
module run_timer
    import dino_pkg::*;
#(
    parameter int FRAMES_PER_SEC = FRAMES_PER_SEC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        new_game,
    input  logic        run,
    input  logic        game_over,
    input  logic        show_best,
    output logic [15:0] nums,
    output logic        new_best,
    output logic [1:0]  state
);

    localparam int            FW   = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FW-1:0] FMAX = FW'(FRAMES_PER_SEC - 1);

    logic          vs_s1, vs_s2, vs_prev;
    logic          tick;
    run_state_t    st, st_nxt;
    logic [FW-1:0] frame_cnt;
    logic          frame_wrap;
    logic          cnt_en;
    logic          sec_en;
    logic [15:0]   cur;
    logic [3:0]    carry;

    // vsync synchroniser plus edge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_s1   <= vsync;
            vs_s2   <= vs_s1;
            vs_prev <= vs_s2;
        end
    end

    assign tick = vs_s2 && !vs_prev;

    // Next-state logic; new_game overrides everything, including game_over.
    always_comb begin
        st_nxt = st;
        if (new_game) begin
            st_nxt = run ? RUN : PAUSED;
        end else begin
            case (st)
                IDLE:    st_nxt = IDLE;
                RUN:     st_nxt = game_over ? OVER : (run ? RUN : PAUSED);
                PAUSED:  st_nxt = game_over ? OVER : (run ? RUN : PAUSED);
                OVER:    st_nxt = IDLE;
                default: st_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= IDLE;
        else
            st <= st_nxt;
    end

    assign state = st;

    // Frame counting only in RUN; a new_game in the same cycle clears instead.
    assign cnt_en     = (st == RUN) && tick && !new_game;
    assign frame_wrap = (frame_cnt == FMAX);

    // Frame counter keeps wrapping even once the digits saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (new_game)
            frame_cnt <= '0;
        else if (cnt_en)
            frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
    end

    assign sec_en = cnt_en && frame_wrap && (cur != BCD_TIME_MAX);

    bcd_digit #(.MOD(10)) u_sec_ones (
        .clk(clk), .rst_n(rst_n), .en(sec_en),   .clr(new_game),
        .digit(cur[3:0]),   .co(carry[0])
    );
    bcd_digit #(.MOD(6))  u_sec_tens (
        .clk(clk), .rst_n(rst_n), .en(carry[0]), .clr(new_game),
        .digit(cur[7:4]),   .co(carry[1])
    );
    bcd_digit #(.MOD(10)) u_min_ones (
        .clk(clk), .rst_n(rst_n), .en(carry[1]), .clr(new_game),
        .digit(cur[11:8]),  .co(carry[2])
    );
    bcd_digit #(.MOD(10)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .en(carry[2]), .clr(new_game),
        .digit(cur[15:12]), .co(carry[3])
    );

`ifdef RUN_TIMER_BEST_EN
    logic [15:0] best;
    logic        beats;

    // BCD digits are ordered, so a plain unsigned compare ranks times.
    assign beats    = (cur > best);
    assign new_best = (st == OVER) && beats;

    // Best record latches on leaving OVER when strictly beaten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            best <= 16'h0000;
        else if (new_best)
            best <= cur;
    end

    // Registered display select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nums <= 16'h0000;
        else
            nums <= show_best ? best : cur;
    end
`else
    logic unused_inputs;
    assign unused_inputs = show_best ^ carry[3];
    assign new_best      = 1'b0;

    // Registered display of the current time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nums <= 16'h0000;
        else
            nums <= cur;
    end
`endif

`ifdef RUN_TIMER_BEST_EN
    logic unused_carry;
    assign unused_carry = carry[3];
`endif

endmodule

// File: tb/tb_run_timer.sv
// Directed plus randomised bench for run_timer. The reference model keeps
// the run time as a plain frame count and derives mm:ss arithmetically.
module tb_run_timer;
    localparam int FPS = 2;

`ifdef RUN_TIMER_BEST_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        new_game = 1'b0;
    logic        run = 1'b0;
    logic        game_over = 1'b0;
    logic        show_best = 1'b0;
    logic [15:0] nums;
    logic        new_best;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 run, 2 paused
    int m_state  = 0;
    int m_frames = 0;
    int m_best_s = 0;

    run_timer #(.FRAMES_PER_SEC(FPS)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .new_game(new_game),
        .run(run), .game_over(game_over), .show_best(show_best),
        .nums(nums), .new_best(new_best), .state(state)
    );

    always #5 clk = ~clk;

    function automatic int cur_s();
        int s;
        s = m_frames / FPS;
        return (s > 5999) ? 5999 : s;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int m, sc;
        m  = s / 60;
        sc = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic logic [15:0] exp_nums();
        return (BEST_EN && show_best) ? to_bcd(m_best_s) : to_bcd(cur_s());
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vsync = 1'b1;
            repeat (2) @(negedge clk);
            vsync = 1'b0;
            repeat (2) @(negedge clk);
            if (m_state == 1) m_frames++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_nums(input string tag);
        repeat (2) @(negedge clk);
        chk(tag, nums, exp_nums());
    endtask

    task automatic pulse_ng();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        m_frames = 0;
        m_state  = run ? 1 : 2;
    endtask

    task automatic set_run(input logic v);
        run = v;
        @(negedge clk);
        if (m_state != 0) m_state = v ? 1 : 2;
    endtask

    task automatic do_over(input string tag);
        logic exp_nb;
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        exp_nb = BEST_EN && (cur_s() > m_best_s);
        chk({tag, "_over_state"}, 16'(state), 16'd3);
        chk({tag, "_new_best"}, 16'(new_best), 16'(exp_nb));
        if (exp_nb) m_best_s = cur_s();
        m_state = 0;
        @(negedge clk);
        chk({tag, "_idle_state"}, 16'(state), 16'd0);
        chk({tag, "_nb_drop"}, 16'(new_best), 16'd0);
    endtask

    initial begin
        int nf, np;
        repeat (3) @(negedge clk);
        chk("rst_nums", nums, 16'h0000);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_new_best", 16'(new_best), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // IDLE ignores vsync
        frames(4);
        chk_nums("idle_no_count");

        // first second
        run = 1'b1;
        @(negedge clk);
        pulse_ng();
        chk("ng_state", 16'(state), 16'd1);
        frames(2 * FPS / 2);
        chk_nums("one_sec");
        chk("one_sec_abs", nums, 16'h0001);

        // 09:59 then minute-tens carry
        pulse_ng();
        frames(599 * FPS);
        chk_nums("t0959");
        chk("t0959_abs", nums, 16'h0959);
        frames(FPS);
        chk_nums("t1000");
        chk("t1000_abs", nums, 16'h1000);

        // run on to saturation
        frames((5999 - 600) * FPS);
        chk_nums("t9959");
        frames(120 * FPS);
        chk_nums("sat_hold");
        chk("sat_abs", nums, 16'h9959);

        // pause freezes
        pulse_ng();
        chk_nums("ng_clear");
        frames(5 * FPS);
        chk_nums("t0005");
        set_run(1'b0);
        chk("paused_state", 16'(state), 16'd2);
        frames(300);
        chk_nums("paused_hold");
        chk("paused_abs", nums, 16'h0005);
        set_run(1'b1);
        chk("resume_state", 16'(state), 16'd1);
        frames(FPS);
        chk_nums("t0006");

        // best record runs A/B/C
        pulse_ng();
        frames(10 * FPS);
        chk_nums("runA");
        do_over("runA");
        chk_nums("idle_hold");
        show_best = 1'b1;
        chk_nums("bestA");
        show_best = 1'b0;
        pulse_ng();
        frames(10 * FPS);
        do_over("runB_tie");
        pulse_ng();
        frames(3 * FPS);
        do_over("runC");
        show_best = 1'b1;
        chk_nums("bestC");
        show_best = 1'b0;

        // randomised runs with pauses
        for (int r = 0; r < 4; r++) begin
            set_run(1'b1);
            pulse_ng();
            nf = $urandom_range(0, 30 * FPS);
            frames(nf);
            set_run(1'b0);
            np = $urandom_range(0, 10);
            frames(np);
            chk_nums("rnd_paused");
            set_run(1'b1);
            frames($urandom_range(0, 20 * FPS));
            chk_nums("rnd_run");
            if ($urandom_range(0, 1) == 1) set_run(1'b0);
            do_over("rnd");
            show_best = 1'($urandom_range(0, 1));
            chk_nums("rnd_show");
            show_best = 1'b0;
        end

        // new_game and game_over together: new_game wins
        set_run(1'b1);
        pulse_ng();
        frames(7 * FPS);
        chk_nums("t0007");
        new_game  = 1'b1;
        game_over = 1'b1;
        @(negedge clk);
        new_game  = 1'b0;
        game_over = 1'b0;
        m_frames  = 0;
        chk("both_state", 16'(state), 16'd1);
        chk("both_new_best", 16'(new_best), 16'd0);
        @(negedge clk);
        chk("both_new_best2", 16'(new_best), 16'd0);
        chk_nums("both_clear");

        // async reset mid-run
        frames(3 * FPS);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_nums", nums, 16'h0000);
        chk("arst_state", 16'(state), 16'd0);
        m_frames = 0;
        m_best_s = 0;
        m_state  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        show_best = 1'b1;
        chk_nums("arst_best");
        show_best = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
